// File: rtl/tsp_fetch_pkg.sv
// Shared definitions for the TSP instruction fetcher: state encoding,
// default widths and the prefetch FIFO depth legality check.
package tsp_fetch_pkg;

  localparam int DEFAULT_ADDR_W     = 13;
  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  // Pointer wrap in the FIFO relies on a power-of-two depth.
  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/tsp_fetch_fifo.sv
// Small synchronous FIFO used as the fetcher's prefetch buffer.
// Head word is presented combinationally so it is visible while it waits.
module tsp_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   occ_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (occ_reg == (PTR_W + 1)'(DEPTH));
  assign empty     = (occ_reg == '0);
  assign occupancy = occ_reg;
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign pop_data  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   occ_reg <= occ_reg + (PTR_W + 1)'(1);
        2'b01:   occ_reg <= occ_reg - (PTR_W + 1)'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: rtl/tsp_instr_fetch.sv
// Streams a contiguous run of BRAM words to the TSP dispatch via a prefetch FIFO.
// Define TSP_FETCH_CHECKSUM_EN to build the XOR checksum of delivered words.
module tsp_instr_fetch
  import tsp_fetch_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              sys_clock,
  input  logic              reset_rtl,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic              instr_last,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  generate
    if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_depth
      $error("tsp_instr_fetch: FIFO_DEPTH must be a power of two and >= 4");
    end
  endgenerate

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic [CNT_W-1:0]  delivered_reg;
  logic              inflight_reg;

  logic              accept;
  logic              issue;
  logic              handshake;
  logic [OCC_W:0]    pending;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_occupancy;

  tsp_fetch_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clock),
    .srst      (reset_rtl),
    .push      (inflight_reg),
    .push_data (bram_dout),
    .pop       (handshake),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occupancy)
  );

  // Buffered words plus the read still in the BRAM pipeline must fit the FIFO.
  assign pending = {1'b0, fifo_occupancy} + {{OCC_W{1'b0}}, inflight_reg};

  assign accept      = (state_reg == ST_IDLE) && start;
  assign issue       = (state_reg == ST_FETCH) && (issued_reg < count_reg) &&
                       !fifo_full && (pending < (OCC_W + 1)'(FIFO_DEPTH));
  assign instr_valid = !fifo_empty;
  assign handshake   = instr_valid && instr_ready;
  assign instr_data  = instr_valid ? fifo_head : '0;
  assign instr_last  = instr_valid && (delivered_reg == count_reg - CNT_W'(1));

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign bram_en   = issue;
  assign bram_addr = base_reg + issued_reg[ADDR_W-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (count == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (issue && (issued_reg + CNT_W'(1) == count_reg)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (handshake && instr_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset_rtl) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      count_reg     <= '0;
      issued_reg    <= '0;
      delivered_reg <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (accept) begin
        base_reg      <= base_addr;
        count_reg     <= count;
        issued_reg    <= '0;
        delivered_reg <= '0;
      end else begin
        if (issue) begin
          issued_reg <= issued_reg + CNT_W'(1);
        end
        if (handshake) begin
          delivered_reg <= delivered_reg + CNT_W'(1);
        end
      end
    end
  end

`ifdef TSP_FETCH_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge sys_clock) begin
    if (reset_rtl) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= '0;
    end else if (handshake) begin
      checksum_reg <= checksum_reg ^ fifo_head;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_tsp_instr_fetch.sv
// Randomized scoreboard bench for tsp_instr_fetch against a BRAM model and
// a reference list of expected words/addresses built at each accepted start.
module tb_tsp_instr_fetch;

  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  logic              sys_clock = 1'b0;
  logic              reset_rtl = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              busy;
  logic              done;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b1;
  logic [DATA_W-1:0] instr_data;
  logic              instr_last;
  logic [DATA_W-1:0] checksum;

  tsp_instr_fetch #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sys_clock   (sys_clock),
    .reset_rtl   (reset_rtl),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .bram_en     (bram_en),
    .bram_addr   (bram_addr),
    .bram_dout   (bram_dout),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_last  (instr_last),
    .checksum    (checksum)
  );

  always #5 sys_clock = ~sys_clock;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always @(posedge sys_clock) begin
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
  } word_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  word_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  bit                model_active = 0;
  bit                done_due = 0;
  bit                exp_done_now = 0;
  logic [DATA_W-1:0] exp_csum = '0;
  int                accept_cyc = 0;
  bit                first_seen = 1;
  int                issued_n = 0;
  int                hs_n = 0;
  bit                prev_stall = 0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  int                ready_mode = 0;
  word_t             w;
  logic [ADDR_W-1:0] a_tmp;
  int                n_req;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Word i of a run is simply the memory word at (base + i) mod 2^ADDR_W.
  function automatic logic [DATA_W-1:0] ref_word(input logic [ADDR_W-1:0] b, input int i);
    logic [ADDR_W-1:0] a;
    a = b + ADDR_W'(i);
    return mem[a];
  endfunction

  // Monitor / scoreboard: checks outputs mid-cycle, then observes inputs.
  always @(negedge sys_clock) begin
    cyc++;
    if (reset_rtl) begin
      exp_q.delete();
      addr_q.delete();
      model_active = 0;
      done_due     = 0;
      prev_stall   = 0;
      first_seen   = 1;
      issued_n     = 0;
      hs_n         = 0;
    end else begin
      exp_done_now = done_due;
      done_due     = 0;
      chk("busy", 64'(busy), 64'(model_active));
      if (done || exp_done_now) chk("done", 64'(done), 64'(exp_done_now));
      if (exp_done_now) chk("checksum", 64'(checksum), 64'(exp_csum));
      if (bram_en) begin
        issued_n++;
        if (addr_q.size() == 0) chk("bram_en_extra", 64'(1), 64'(0));
        else chk("bram_addr", 64'(bram_addr), 64'(addr_q.pop_front()));
        chk("outstanding_le_depth", 64'((issued_n - hs_n) <= FIFO_DEPTH), 64'(1));
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(instr_valid), 64'(1));
        chk("hold_data", 64'(instr_data), 64'(prev_data));
        chk("hold_last", 64'(instr_last), 64'(prev_last));
      end
      if (instr_valid && !first_seen) begin
        chk("first_latency", 64'(cyc - accept_cyc), 64'(3));
        first_seen = 1;
      end
      if (instr_valid && instr_ready) begin
        hs_n++;
        if (exp_q.size() == 0) begin
          chk("instr_extra", 64'(1), 64'(0));
        end else begin
          w = exp_q.pop_front();
          chk("instr_data", 64'(instr_data), 64'(w.data));
          chk("instr_last", 64'(instr_last), 64'(w.last));
          if (w.last) done_due = 1;
        end
      end
      prev_stall = instr_valid && !instr_ready;
      prev_data  = instr_data;
      prev_last  = instr_last;

      if (start && !model_active) begin
        n_req        = int'(count);
        model_active = 1;
        accept_cyc   = cyc;
        first_seen   = (n_req == 0);
        issued_n     = 0;
        hs_n         = 0;
        exp_csum     = '0;
        for (int i = 0; i < n_req; i++) begin
          w.data = ref_word(base_addr, i);
          w.last = (i == n_req - 1);
          a_tmp  = base_addr + ADDR_W'(i);
          exp_q.push_back(w);
          addr_q.push_back(a_tmp);
`ifdef TSP_FETCH_CHECKSUM_EN
          exp_csum = exp_csum ^ w.data;
`endif
        end
        if (n_req == 0) done_due = 1;
        $display("run: cycle=%0d base=0x%04h count=%0d ready_mode=%0d", cyc, base_addr, n_req, ready_mode);
      end
      if (exp_done_now) model_active = 0;
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    forever begin
      @(posedge sys_clock);
      #1;
      case (ready_mode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = ~instr_ready;
        default: instr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] b, input int n);
    @(posedge sys_clock);
    #1;
    start     = 1'b1;
    base_addr = b;
    count     = (ADDR_W + 1)'(n);
    @(posedge sys_clock);
    #1;
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);
    count     = (ADDR_W + 1)'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge sys_clock);
      #1;
    end
    chk("done_timeout", 64'(seen), 64'(1));
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("addr_q_drained", 64'(addr_q.size()), 64'(0));
  endtask

  task automatic chk_outputs_zero();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_bram_en", 64'(bram_en), 64'(0));
    chk("rst_bram_addr", 64'(bram_addr), 64'(0));
    chk("rst_instr_valid", 64'(instr_valid), 64'(0));
    chk("rst_instr_data", 64'(instr_data), 64'(0));
    chk("rst_instr_last", 64'(instr_last), 64'(0));
    chk("rst_checksum", 64'(checksum), 64'(0));
  endtask

  initial begin
    bit reached;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[16'h0010] = 32'hA;
    mem[16'h0011] = 32'hB;
    mem[16'h0012] = 32'hC;

    repeat (3) @(posedge sys_clock);
    #1;
    chk_outputs_zero();
    reset_rtl = 1'b0;

    // Basic run
    ready_mode = 0;
    do_start(13'h0010, 3);
    wait_done(100);

    // Backpressure with ready toggling each cycle
    ready_mode = 1;
    do_start(13'h0100, 8);
    wait_done(200);

    // Address wrap past the top of memory
    ready_mode = 0;
    do_start(13'h1FFE, 4);
    wait_done(100);

    // Zero count
    do_start(13'h0200, 0);
    wait_done(5);

    // Start while busy is ignored
    ready_mode = 2;
    do_start(13'h0300, 6);
    repeat (2) @(posedge sys_clock);
    #1;
    do_start(13'h0700, 5);
    wait_done(300);

    // Reset mid-run after 5 handshakes, then a fresh 2-word run
    do_start(13'h0400, 16);
    reached = 0;
    for (int i = 0; i < 300; i++) begin
      if (hs_n >= 5) begin
        reached = 1;
        break;
      end
      @(posedge sys_clock);
      #1;
    end
    chk("five_handshakes", 64'(reached), 64'(1));
    reset_rtl = 1'b1;
    @(posedge sys_clock);
    #1;
    chk_outputs_zero();
    reset_rtl = 1'b0;
    ready_mode = 0;
    do_start(13'h0500, 2);
    wait_done(100);
    chk("post_reset_words", 64'(hs_n), 64'(2));

    // Random runs
    for (int r = 0; r < 12; r++) begin
      ready_mode = $urandom_range(0, 2);
      do_start(ADDR_W'($urandom), $urandom_range(0, 24));
      wait_done(2000);
    end

    // Full memory sweep: count = 2^ADDR_W
    ready_mode = 0;
    do_start(13'h1234, MEM_WORDS);
    wait_done(MEM_WORDS + 100);

    repeat (5) @(posedge sys_clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
